// File: rtl/perceptron_trainer.sv
// Perceptron training engine: reads the weight vector for a resolved branch, recomputes y,
// applies the saturating training rule and writes the vector back when training is needed.
module perceptron_trainer #(
    parameter int unsigned N_HIST = 8,
    parameter int unsigned W_BITS = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned THETA  = 29,
    parameter int unsigned Y_W    = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         upd_valid,
    output logic                         upd_ready,
    input  logic [ADDR_W-1:0]            upd_index,
    input  logic [N_HIST-1:0]            upd_hist,
    input  logic                         upd_taken,
    output logic                         rd_req_valid,
    input  logic                         rd_req_ready,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic                         rd_rsp_valid,
    input  logic [(N_HIST+1)*W_BITS-1:0] rd_rsp_data,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [(N_HIST+1)*W_BITS-1:0] wr_data,
    output logic [15:0]                  train_cnt,
    output logic [15:0]                  skip_cnt
);

    localparam int unsigned VEC_W = (N_HIST + 1) * W_BITS;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        CALC    = 3'd3,
        WR      = 3'd4
    } state_t;

    state_t state, next_state;

    logic [N_HIST-1:0] hist_q;
    logic              taken_q;
    logic [VEC_W-1:0]  vec_q;

    logic             capture, load_vec, load_wr, inc_train, inc_skip;
    logic [Y_W-1:0]   y_c;
    logic [Y_W-1:0]   y_abs_c;
    logic             pred_c;
    logic             train_c;
    logic [VEC_W-1:0] new_vec_c;

    // One saturating +/-1 step on a signed weight.
    function automatic logic [W_BITS-1:0] sat_step(input logic [W_BITS-1:0] w, input logic inc);
        logic [W_BITS:0] s;
        s = {w[W_BITS-1], w} + (inc ? (W_BITS+1)'(1) : {(W_BITS+1){1'b1}});
        if (s[W_BITS] != s[W_BITS-1])
            sat_step = s[W_BITS] ? {1'b1, {(W_BITS-1){1'b0}}} : {1'b0, {(W_BITS-1){1'b1}}};
        else
            sat_step = s[W_BITS-1:0];
    endfunction

    // Perceptron output and updated vector from the captured weights.
    always_comb begin
        logic [W_BITS-1:0] w;
        y_c       = '0;
        new_vec_c = '0;
        for (int j = 0; j < int'(N_HIST); j++) begin
            w = vec_q[j*W_BITS +: W_BITS];
            if (hist_q[j])
                y_c = y_c + {{(Y_W-W_BITS){w[W_BITS-1]}}, w};
            else
                y_c = y_c - {{(Y_W-W_BITS){w[W_BITS-1]}}, w};
            new_vec_c[j*W_BITS +: W_BITS] = sat_step(w, hist_q[j] == taken_q);
        end
        w = vec_q[N_HIST*W_BITS +: W_BITS];
        y_c = y_c + {{(Y_W-W_BITS){w[W_BITS-1]}}, w};
        new_vec_c[N_HIST*W_BITS +: W_BITS] = sat_step(w, taken_q);
        pred_c  = ~y_c[Y_W-1];
        y_abs_c = y_c[Y_W-1] ? -y_c : y_c;
        train_c = (pred_c != taken_q) || (y_abs_c <= Y_W'(THETA));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        load_vec   = 1'b0;
        load_wr    = 1'b0;
        inc_train  = 1'b0;
        inc_skip   = 1'b0;
        case (state)
            IDLE: if (upd_valid) begin
                capture    = 1'b1;
                next_state = RD_REQ;
            end
            RD_REQ: if (rd_req_ready) next_state = RD_WAIT;
            RD_WAIT: if (rd_rsp_valid) begin
                load_vec   = 1'b1;
                next_state = CALC;
            end
            CALC: begin
                if (train_c) begin
                    load_wr    = 1'b1;
                    next_state = WR;
                end else begin
                    inc_skip   = 1'b1;
                    next_state = IDLE;
                end
            end
            WR: if (wr_ready) begin
                inc_train  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_ready    <= 1'b1;
            rd_req_valid <= 1'b0;
            wr_valid     <= 1'b0;
        end else begin
            upd_ready    <= (next_state == IDLE);
            rd_req_valid <= (next_state == RD_REQ);
            wr_valid     <= (next_state == WR);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q    <= '0;
            taken_q   <= 1'b0;
            vec_q     <= '0;
            rd_addr   <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            train_cnt <= '0;
            skip_cnt  <= '0;
        end else begin
            if (capture) begin
                rd_addr <= upd_index;
                hist_q  <= upd_hist;
                taken_q <= upd_taken;
            end
            if (load_vec) vec_q <= rd_rsp_data;
            if (load_wr) begin
                wr_addr <= rd_addr;
                wr_data <= new_vec_c;
            end
            if (inc_train) train_cnt <= train_cnt + CNT_W'(1);
            if (inc_skip)  skip_cnt  <= skip_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer: vector table of training cases plus stall and reset sequences.
module tb_perceptron_trainer;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd_valid;
    logic        upd_ready;
    logic [7:0]  upd_index;
    logic [7:0]  upd_hist;
    logic        upd_taken;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [7:0]  rd_addr;
    logic        rd_rsp_valid;
    logic [71:0] rd_rsp_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [71:0] wr_data;
    logic [15:0] train_cnt;
    logic [15:0] skip_cnt;

    int checks = 0;
    int errors = 0;
    int exp_train_cnt = 0;
    int exp_skip_cnt  = 0;

    typedef struct {
        logic [7:0]  idx;
        logic [71:0] vec;
        logic [7:0]  hist;
        logic        taken;
        bit          exp_train;
        logic [71:0] exp_data;
    } vec_t;

    vec_t tbl[8];

    perceptron_trainer dut (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
        .upd_hist(upd_hist), .upd_taken(upd_taken),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .train_cnt(train_cnt), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one update through the trainer, acting as the weight table.
    task automatic run_update(input vec_t v, input int rd_stall, input int wr_stall);
        @(negedge clk);
        check("upd_ready_idle", 72'(upd_ready), 72'(1));
        upd_valid = 1'b1; upd_index = v.idx; upd_hist = v.hist; upd_taken = v.taken;
        rd_req_ready = 1'b0;
        @(negedge clk);
        upd_valid = 1'b0; upd_index = ~v.idx; upd_hist = ~v.hist; upd_taken = ~v.taken;
        check("rd_req_valid", 72'(rd_req_valid), 72'(1));
        check("rd_addr", 72'(rd_addr), 72'(v.idx));
        check("upd_ready_busy", 72'(upd_ready), 72'(0));
        for (int i = 0; i < rd_stall; i++) begin
            @(negedge clk);
            check("rd_req_valid_hold", 72'(rd_req_valid), 72'(1));
            check("rd_addr_hold", 72'(rd_addr), 72'(v.idx));
            check("upd_ready_stall", 72'(upd_ready), 72'(0));
        end
        rd_req_ready = 1'b1;
        @(negedge clk);
        rd_req_ready = 1'b0;
        check("rd_req_valid_drop", 72'(rd_req_valid), 72'(0));
        rd_rsp_valid = 1'b1; rd_rsp_data = v.vec;
        @(negedge clk);
        rd_rsp_valid = 1'b0; rd_rsp_data = ~v.vec;
        check("calc_wr_valid", 72'(wr_valid), 72'(0));
        check("calc_upd_ready", 72'(upd_ready), 72'(0));
        @(negedge clk);
        if (v.exp_train) begin
            for (int i = 0; i <= wr_stall; i++) begin
                check("wr_valid", 72'(wr_valid), 72'(1));
                check("wr_addr", 72'(wr_addr), 72'(v.idx));
                check("wr_data", wr_data, v.exp_data);
                check("wr_upd_ready", 72'(upd_ready), 72'(0));
                if (i < wr_stall) @(negedge clk);
            end
            wr_ready = 1'b1;
            @(negedge clk);
            wr_ready = 1'b0;
            exp_train_cnt++;
            check("wr_valid_drop", 72'(wr_valid), 72'(0));
        end else begin
            exp_skip_cnt++;
            check("skip_no_write", 72'(wr_valid), 72'(0));
        end
        check("upd_ready_after", 72'(upd_ready), 72'(1));
        check("train_cnt", 72'(train_cnt), 72'(exp_train_cnt));
        check("skip_cnt", 72'(skip_cnt), 72'(exp_skip_cnt));
    endtask

    task automatic check_reset_outputs();
        check("rst_upd_ready", 72'(upd_ready), 72'(1));
        check("rst_rd_req_valid", 72'(rd_req_valid), 72'(0));
        check("rst_wr_valid", 72'(wr_valid), 72'(0));
        check("rst_rd_addr", 72'(rd_addr), 72'(0));
        check("rst_wr_addr", 72'(wr_addr), 72'(0));
        check("rst_wr_data", wr_data, 72'(0));
        check("rst_train_cnt", 72'(train_cnt), 72'(0));
        check("rst_skip_cnt", 72'(skip_cnt), 72'(0));
    endtask

    initial begin
        // idx, vec, hist, taken, train, expected write data (bias in the top byte)
        tbl[0] = '{8'h11, 72'h000000000000000000, 8'hFF, 1'b1, 1'b1, 72'h010101010101010101};
        tbl[1] = '{8'h22, 72'h0A0A0A0A0A0A0A0A0A, 8'hFF, 1'b1, 1'b0, 72'h0};
        tbl[2] = '{8'h33, 72'h7F7F7F7F7F7F7F7F7F, 8'h00, 1'b1, 1'b1, 72'h7F7E7E7E7E7E7E7E7E};
        tbl[3] = '{8'h44, 72'h808080808080808080, 8'h00, 1'b0, 1'b1, 72'h808181818181818181};
        tbl[4] = '{8'h55, 72'hFD0000000000000005, 8'h01, 1'b0, 1'b1, 72'hFC0101010101010104};
        tbl[5] = '{8'h66, 72'hF0F0F0F0F0F0F0F0F0, 8'hFF, 1'b0, 1'b0, 72'h0};
        tbl[6] = '{8'h77, 72'h1D0000000000000000, 8'hFF, 1'b1, 1'b1, 72'h1E0101010101010101};
        tbl[7] = '{8'h88, 72'h1E0000000000000000, 8'hFF, 1'b1, 1'b0, 72'h0};

        rst = 1'b0;
        upd_valid = 1'b0; upd_index = '0; upd_hist = '0; upd_taken = 1'b0;
        rd_req_ready = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_data = '0; wr_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;

        for (int k = 0; k < 8; k++) run_update(tbl[k], 0, 0);

        // Back-pressure on both table ports.
        run_update(tbl[0], 3, 5);

        // Async reset while waiting for the read response.
        @(negedge clk);
        upd_valid = 1'b1; upd_index = 8'h99; upd_hist = 8'hFF; upd_taken = 1'b1;
        rd_req_ready = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        @(negedge clk);
        rd_req_ready = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;
        exp_train_cnt = 0;
        exp_skip_cnt  = 0;
        rd_rsp_valid = 1'b1; rd_rsp_data = 72'h0;
        @(negedge clk);
        rd_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_rsp_no_write", 72'(wr_valid), 72'(0));
            check("late_rsp_idle", 72'(upd_ready), 72'(1));
            check("late_rsp_no_read", 72'(rd_req_valid), 72'(0));
            @(negedge clk);
        end
        run_update(tbl[0], 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
